// File: rtl/l1_refill_ctrl.sv
// L1 miss refill controller: optional dirty-victim writeback, line read, then
// a single-cycle tag/data array fill followed by a one-cycle done pulse.
module l1_refill_ctrl #(
    parameter int WAY_NUM   = 4,
    parameter int IDX_WIDTH = 8,
    parameter int TAG_WIDTH = 20,
    parameter int OFF_WIDTH = 4,
    parameter int LINE_W    = 8 * (2 ** OFF_WIDTH),
    parameter int ADDR_W    = TAG_WIDTH + IDX_WIDTH + OFF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss_req,
    input  logic [IDX_WIDTH-1:0] miss_idx,
    input  logic [TAG_WIDTH-1:0] miss_tag,
    input  logic [WAY_NUM-1:0]   way_vect,
    input  logic                 evict_val,
    input  logic                 evict_dirty,
    input  logic [TAG_WIDTH-1:0] evict_tag,
    input  logic [LINE_W-1:0]    evict_data,
    output logic                 busy,
    output logic                 mem_req_val,
    output logic                 mem_req_cmd,
    output logic [ADDR_W-1:0]    mem_req_addr,
    output logic [LINE_W-1:0]    mem_req_wdata,
    input  logic                 mem_req_ack,
    input  logic                 mem_rsp_val,
    input  logic [LINE_W-1:0]    mem_rsp_data,
    output logic                 fill_wen,
    output logic [IDX_WIDTH-1:0] fill_idx,
    output logic [WAY_NUM-1:0]   fill_way_vect,
    output logic [TAG_WIDTH-1:0] fill_tag,
    output logic [LINE_W-1:0]    fill_data,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {
        IDLE, WB_REQ, RD_REQ, RD_WAIT, FILL, DONE
    } state_t;

    state_t state, state_nxt;

    logic [IDX_WIDTH-1:0] cap_idx;
    logic [TAG_WIDTH-1:0] cap_tag;
    logic [WAY_NUM-1:0]   cap_way;
    logic [TAG_WIDTH-1:0] cap_etag;
    logic [LINE_W-1:0]    cap_edata;
    logic [LINE_W-1:0]    cap_line;
    logic                 accept;

    // DONE is not busy, so a back-to-back miss can be taken in that cycle.
    assign accept = miss_req && (state == IDLE || state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    state_nxt = (evict_val && evict_dirty) ? WB_REQ : RD_REQ;
                else
                    state_nxt = IDLE;
            end
            WB_REQ:  if (mem_req_ack) state_nxt = RD_REQ;
            RD_REQ:  if (mem_req_ack) state_nxt = RD_WAIT;
            RD_WAIT: if (mem_rsp_val) state_nxt = FILL;
            FILL:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_idx   <= '0;
            cap_tag   <= '0;
            cap_way   <= '0;
            cap_etag  <= '0;
            cap_edata <= '0;
            cap_line  <= '0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                cap_idx   <= miss_idx;
                cap_tag   <= miss_tag;
                cap_way   <= way_vect;
                cap_etag  <= evict_tag;
                cap_edata <= evict_data;
                if (!$onehot(way_vect)) err <= 1'b1;
            end
            if (state == RD_WAIT && mem_rsp_val) cap_line <= mem_rsp_data;
        end
    end

    // All outputs decode from registered state/captures, so request fields
    // hold steady under backpressure without extra holding logic.
    always_comb begin
        busy          = 1'b0;
        mem_req_val   = 1'b0;
        mem_req_cmd   = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        fill_wen      = 1'b0;
        fill_data     = '0;
        done          = 1'b0;
        case (state)
            WB_REQ: begin
                busy          = 1'b1;
                mem_req_val   = 1'b1;
                mem_req_cmd   = 1'b1;
                mem_req_addr  = {cap_etag, cap_idx, {OFF_WIDTH{1'b0}}};
                mem_req_wdata = cap_edata;
            end
            RD_REQ: begin
                busy         = 1'b1;
                mem_req_val  = 1'b1;
                mem_req_addr = {cap_tag, cap_idx, {OFF_WIDTH{1'b0}}};
            end
            RD_WAIT: busy = 1'b1;
            FILL: begin
                busy      = 1'b1;
                fill_wen  = 1'b1;
                fill_data = cap_line;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign fill_idx      = cap_idx;
    assign fill_way_vect = cap_way;
    assign fill_tag      = cap_tag;

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Directed bench for l1_refill_ctrl: clean/dirty refills, backpressure,
// ignored strobes, err stickiness and mid-transaction reset.
module tb_l1_refill_ctrl;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              miss_req;
    logic [7:0]        miss_idx;
    logic [19:0]       miss_tag;
    logic [3:0]        way_vect;
    logic              evict_val, evict_dirty;
    logic [19:0]       evict_tag;
    logic [LINE_W-1:0] evict_data;
    logic              busy, mem_req_val, mem_req_cmd;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LINE_W-1:0] mem_req_wdata;
    logic              mem_req_ack, mem_rsp_val;
    logic [LINE_W-1:0] mem_rsp_data;
    logic              fill_wen;
    logic [7:0]        fill_idx;
    logic [3:0]        fill_way_vect;
    logic [19:0]       fill_tag;
    logic [LINE_W-1:0] fill_data;
    logic              done, err;

    int vec_cnt = 0;
    int mis_cnt = 0;

    localparam logic [LINE_W-1:0] EDATA = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    localparam logic [LINE_W-1:0] RDAT1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [LINE_W-1:0] RDAT2 = 128'hA5A5_A5A5_0000_FFFF_1234_5678_9ABC_DEF0;
    localparam logic [LINE_W-1:0] RDAT3 = 128'h0F0F_0F0F_F0F0_F0F0_0101_0202_0303_0404;

    l1_refill_ctrl dut (
        .clk(clk), .rst(rst),
        .miss_req(miss_req), .miss_idx(miss_idx), .miss_tag(miss_tag),
        .way_vect(way_vect), .evict_val(evict_val), .evict_dirty(evict_dirty),
        .evict_tag(evict_tag), .evict_data(evict_data),
        .busy(busy), .mem_req_val(mem_req_val), .mem_req_cmd(mem_req_cmd),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_req_ack(mem_req_ack), .mem_rsp_val(mem_rsp_val),
        .mem_rsp_data(mem_rsp_data),
        .fill_wen(fill_wen), .fill_idx(fill_idx), .fill_way_vect(fill_way_vect),
        .fill_tag(fill_tag), .fill_data(fill_data),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one cycle; inputs set after this are sampled at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic miss(input logic [7:0] idx, input logic [19:0] tag,
                        input logic [3:0] way, input logic dirty,
                        input logic [19:0] etag);
        miss_req    = 1'b1;
        miss_idx    = idx;
        miss_tag    = tag;
        way_vect    = way;
        evict_val   = dirty;
        evict_dirty = dirty;
        evict_tag   = etag;
        evict_data  = EDATA;
    endtask

    task automatic clr_miss();
        miss_req = 1'b0; miss_idx = '0; miss_tag = '0; way_vect = '0;
        evict_val = 1'b0; evict_dirty = 1'b0; evict_tag = '0; evict_data = '0;
    endtask

    initial begin
        rst = 1'b1;
        clr_miss();
        mem_req_ack = 1'b0; mem_rsp_val = 1'b0; mem_rsp_data = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_val", mem_req_val, 0);
        chk("rst_err", err, 0);
        chk("rst_done", done, 0);
        chk("rst_fill", fill_wen, 0);
        step(); step();
        rst = 1'b0;
        step();

        // Clean miss, immediate ack/rsp: minimum-latency path
        miss(8'h12, 20'h0ABCD, 4'b0100, 1'b0, 20'h0);
        chk("c_busy_n", busy, 0);
        step(); clr_miss();
        chk("c_busy_n1", busy, 1);
        chk("c_val", mem_req_val, 1);
        chk("c_cmd", mem_req_cmd, 0);
        chk("c_addr", mem_req_addr, 32'h0ABCD120);
        chk("c_wdata", mem_req_wdata, 0);
        mem_req_ack = 1'b1;
        step(); mem_req_ack = 1'b0;
        chk("c_val_drop", mem_req_val, 0);
        chk("c_fill_n2", fill_wen, 0);
        mem_rsp_val = 1'b1; mem_rsp_data = RDAT1;
        step(); mem_rsp_val = 1'b0; mem_rsp_data = '0;
        chk("c_fill", fill_wen, 1);
        chk("c_fway", fill_way_vect, 4'b0100);
        chk("c_fidx", fill_idx, 8'h12);
        chk("c_ftag", fill_tag, 20'h0ABCD);
        chk("c_fdata", fill_data, RDAT1);
        step();
        chk("c_done", done, 1);
        chk("c_done_busy", busy, 0);
        chk("c_fill_once", fill_wen, 0);
        chk("c_fdata0", fill_data, 0);
        step();
        chk("c_done_once", done, 0);
        chk("c_err0", err, 0);

        // Spurious response in IDLE
        mem_rsp_val = 1'b1; mem_rsp_data = RDAT3;
        step(); mem_rsp_val = 1'b0;
        chk("sp_idle_fill", fill_wen, 0);
        chk("sp_idle_busy", busy, 0);

        // Dirty evict with 5 cycles of backpressure in WB_REQ and RD_REQ
        miss(8'hFF, 20'h12345, 4'b0010, 1'b1, 20'h00001);
        step(); clr_miss();
        for (int i = 0; i < 5; i++) begin
            chk("d_wb_val", mem_req_val, 1);
            chk("d_wb_cmd", mem_req_cmd, 1);
            chk("d_wb_addr", mem_req_addr, 32'h00001FF0);
            chk("d_wb_wdata", mem_req_wdata, EDATA);
            step();
        end
        chk("d_wb_still", mem_req_cmd, 1);
        mem_req_ack = 1'b1;
        step(); mem_req_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("d_rd_val", mem_req_val, 1);
            chk("d_rd_cmd", mem_req_cmd, 0);
            chk("d_rd_addr", mem_req_addr, 32'h12345FF0);
            chk("d_rd_wdata", mem_req_wdata, 0);
            step();
        end
        mem_req_ack = 1'b1;
        step(); mem_req_ack = 1'b0;
        chk("d_no_dup", mem_req_val, 0);
        // miss_req while busy in RD_WAIT must not disturb the capture
        miss(8'h33, 20'hFFFFF, 4'b1000, 1'b1, 20'hEEEEE);
        step(); clr_miss();
        chk("d_wait_val", mem_req_val, 0);
        chk("d_wait_busy", busy, 1);
        mem_rsp_val = 1'b1; mem_rsp_data = RDAT2;
        step(); mem_rsp_val = 1'b0; mem_rsp_data = '0;
        chk("d_fill", fill_wen, 1);
        chk("d_ftag", fill_tag, 20'h12345);
        chk("d_fidx", fill_idx, 8'hFF);
        chk("d_fway", fill_way_vect, 4'b0010);
        chk("d_fdata", fill_data, RDAT2);
        step();
        chk("d_done", done, 1);
        // New miss accepted in the DONE cycle; bad way vector sets err
        miss(8'h01, 20'h55555, 4'b0110, 1'b0, 20'h0);
        step(); clr_miss();
        chk("n_accept", mem_req_val, 1);
        chk("n_addr", mem_req_addr, 32'h55555010);
        chk("n_err", err, 1);
        // Spurious response while in RD_REQ
        mem_rsp_val = 1'b1; mem_rsp_data = RDAT3;
        step(); mem_rsp_val = 1'b0;
        chk("sp_rd_fill", fill_wen, 0);
        chk("sp_rd_val", mem_req_val, 1);
        mem_req_ack = 1'b1;
        step(); mem_req_ack = 1'b0;
        mem_rsp_val = 1'b1; mem_rsp_data = RDAT1;
        step(); mem_rsp_val = 1'b0;
        chk("n_fill", fill_wen, 1);
        chk("n_fway", fill_way_vect, 4'b0110);
        chk("n_fdata", fill_data, RDAT1);
        step();
        chk("n_done", done, 1);
        step();
        chk("n_err_sticky", err, 1);

        // Reset in the middle of RD_WAIT
        miss(8'h44, 20'h0BEEF, 4'b0001, 1'b0, 20'h0);
        step(); clr_miss();
        mem_req_ack = 1'b1;
        step(); mem_req_ack = 1'b0;
        chk("r_busy_pre", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("r_busy", busy, 0);
        chk("r_val", mem_req_val, 0);
        chk("r_err", err, 0);
        chk("r_ftag", fill_tag, 0);
        step();
        rst = 1'b0;
        mem_rsp_val = 1'b1; mem_rsp_data = RDAT2;
        step(); mem_rsp_val = 1'b0;
        chk("r_late_fill", fill_wen, 0);
        chk("r_late_busy", busy, 0);
        step();
        chk("r_late_done", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
